lambert_multi: RTL and testbench

Successor to the single-light float Lambert shader. Shades one hit per input beat from a normalised surface normal, using NUM_LIGHTS configurable directional lights, an ambient term and a per-material colour palette. Arithmetic is signed fixed point, and one light is processed per clock. Sits between the normal-generation stage and the pixel writer; the input and output are AXI-Stream-style valid/ready.

---
 rtl/lambert_multi_if.sv | 35 +++
 rtl/lambert_multi.sv | 183 ++++++++++++++++++
 tb/tb_lambert_multi.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lambert_multi_if.sv
// Stream bundle for lambert_multi: normal+material in, RGB pixel out.
interface lambert_multi_if #(
  parameter int SIZE          = 16,
  parameter int NUM_MATERIALS = 4
);
  localparam int MW = $clog2(NUM_MATERIALS);

  logic [3*SIZE-1:0] normal_axis_tdata;
  logic [MW-1:0]     material_axis_tdata;
  logic              normal_axis_tvalid;
  logic              normal_axis_tready;
  logic [23:0]       pixel_axis_tdata;
  logic              pixel_axis_tvalid;
  logic              pixel_axis_tready;

  modport master (
    output normal_axis_tdata,
    output material_axis_tdata,
    output normal_axis_tvalid,
    input  normal_axis_tready,
    input  pixel_axis_tdata,
    input  pixel_axis_tvalid,
    output pixel_axis_tready
  );

  modport slave (
    input  normal_axis_tdata,
    input  material_axis_tdata,
    input  normal_axis_tvalid,
    output normal_axis_tready,
    output pixel_axis_tdata,
    output pixel_axis_tvalid,
    input  pixel_axis_tready
  );
endinterface

// File: rtl/lambert_multi.sv
// Multi-light fixed-point Lambert shader, one light per clock.
// LAMBERT_MULTI_HALF_EN selects half-Lambert wrap lighting.
module lambert_multi #(
  parameter int SIZE          = 16,
  parameter int FRAC          = 14,
  parameter int NUM_LIGHTS    = 4,
  parameter int NUM_MATERIALS = 4
) (
  input  logic aclk,
  input  logic areset,
  lambert_multi_if.slave s,
  input  logic cfg_we,
  input  logic [$clog2(NUM_LIGHTS+1+NUM_MATERIALS)-1:0] cfg_addr,
  input  logic [3*SIZE+9:0] cfg_wdata
);
  localparam int W    = 2*SIZE+2;
  localparam int LW   = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam int MW   = $clog2(NUM_MATERIALS);
  localparam int AW   = $clog2(NUM_LIGHTS+1+NUM_MATERIALS);
  localparam int ACCW = SIZE+4+$clog2(NUM_LIGHTS+1);
  localparam int ONE  = 1 << FRAC;

  typedef enum logic [1:0] {IDLE, ACCUM, COLOR, OUT} st_t;

  st_t               st_q, st_d;
  logic              rdy_q, rdy_d;
  logic              vld_q, vld_d;
  logic [23:0]       pix_q, pix_d;
  logic [3*SIZE-1:0] nrm_q, nrm_d;
  logic [MW-1:0]     mid_q, mid_d;
  logic [LW-1:0]     i_q, i_d;
  logic [ACCW-1:0]   acc_q, acc_d;

  logic              len_q  [NUM_LIGHTS];
  logic              len_d  [NUM_LIGHTS];
  logic [8:0]        lint_q [NUM_LIGHTS];
  logic [8:0]        lint_d [NUM_LIGHTS];
  logic [3*SIZE-1:0] ldir_q [NUM_LIGHTS];
  logic [3*SIZE-1:0] ldir_d [NUM_LIGHTS];
  logic [SIZE-1:0]   amb_q, amb_d;
  logic [23:0]       mcol_q [NUM_MATERIALS];
  logic [23:0]       mcol_d [NUM_MATERIALS];

  logic signed [SIZE-1:0] nx, ny, nz;
  logic signed [SIZE-1:0] lx, ly, lz;
  logic signed [W-1:0]    d_raw, d_w;
  logic [FRAC:0]          d_c;
  logic [FRAC:0]          a_sat;
  logic [23:0]            col;

  assign s.normal_axis_tready = rdy_q;
  assign s.pixel_axis_tvalid  = vld_q;
  assign s.pixel_axis_tdata   = pix_q;

  always_comb begin
    nx = nrm_q[SIZE-1:0];
    ny = nrm_q[2*SIZE-1:SIZE];
    nz = nrm_q[3*SIZE-1:2*SIZE];
    lx = ldir_q[i_q][SIZE-1:0];
    ly = ldir_q[i_q][2*SIZE-1:SIZE];
    lz = ldir_q[i_q][3*SIZE-1:2*SIZE];
    d_raw = (W'(nx) * W'(lx) +
             W'(ny) * W'(ly) +
             W'(nz) * W'(lz)) >>> FRAC;
`ifdef LAMBERT_MULTI_HALF_EN
    d_w = (d_raw + W'(ONE)) >>> 1;
`else
    d_w = d_raw;
`endif
    if (d_w < 0)
      d_c = '0;
    else if (d_w > W'(ONE))
      d_c = (FRAC+1)'(ONE);
    else
      d_c = d_w[FRAC:0];
    a_sat = (acc_q > ACCW'(ONE)) ?
            (FRAC+1)'(ONE) : acc_q[FRAC:0];
    col = mcol_q[mid_q];
  end

  always_comb begin
    st_d   = st_q;
    vld_d  = vld_q;
    pix_d  = pix_q;
    nrm_d  = nrm_q;
    mid_d  = mid_q;
    i_d    = i_q;
    acc_d  = acc_q;
    len_d  = len_q;
    lint_d = lint_q;
    ldir_d = ldir_q;
    amb_d  = amb_q;
    mcol_d = mcol_q;

    if (cfg_we) begin
      for (int k = 0; k < NUM_LIGHTS; k++) begin
        if (cfg_addr == AW'(k)) begin
          len_d[k]  = cfg_wdata[3*SIZE+9];
          lint_d[k] = cfg_wdata[3*SIZE+8:3*SIZE];
          ldir_d[k] = cfg_wdata[3*SIZE-1:0];
        end
      end
      if (cfg_addr == AW'(NUM_LIGHTS))
        amb_d = cfg_wdata[SIZE-1:0];
      for (int k = 0; k < NUM_MATERIALS; k++) begin
        if (cfg_addr == AW'(NUM_LIGHTS+1+k))
          mcol_d[k] = cfg_wdata[23:0];
      end
    end

    unique case (st_q)
      IDLE: begin
        if (s.normal_axis_tvalid && rdy_q) begin
          nrm_d = s.normal_axis_tdata;
          mid_d = s.material_axis_tdata;
          acc_d = ACCW'(amb_q);
          i_d   = '0;
          st_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (len_q[i_q])
          acc_d = acc_q + ACCW'(((FRAC+10)'(d_c) *
                  (FRAC+10)'(lint_q[i_q])) >> 8);
        if (i_q == LW'(NUM_LIGHTS-1))
          st_d = COLOR;
        else
          i_d = i_q + LW'(1);
      end
      COLOR: begin
        for (int c = 0; c < 3; c++)
          pix_d[8*c+:8] = 8'(((FRAC+9)'(a_sat) *
                          (FRAC+9)'(col[8*c+:8])) >> FRAC);
        vld_d = 1'b1;
        st_d  = OUT;
      end
      OUT: begin
        if (s.pixel_axis_tready) begin
          vld_d = 1'b0;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase

    rdy_d = (st_d == IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st_q  <= IDLE;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      pix_q <= '0;
      nrm_q <= '0;
      mid_q <= '0;
      i_q   <= '0;
      acc_q <= '0;
      amb_q <= '0;
      for (int k = 0; k < NUM_LIGHTS; k++) begin
        len_q[k]  <= 1'b0;
        lint_q[k] <= '0;
        ldir_q[k] <= '0;
      end
      for (int k = 0; k < NUM_MATERIALS; k++)
        mcol_q[k] <= 24'hFFFFFF;
    end else begin
      st_q   <= st_d;
      rdy_q  <= rdy_d;
      vld_q  <= vld_d;
      pix_q  <= pix_d;
      nrm_q  <= nrm_d;
      mid_q  <= mid_d;
      i_q    <= i_d;
      acc_q  <= acc_d;
      amb_q  <= amb_d;
      len_q  <= len_d;
      lint_q <= lint_d;
      ldir_q <= ldir_d;
      mcol_q <= mcol_d;
    end
  end
endmodule

// File: tb/tb_lambert_multi.sv
// Self-checking bench for lambert_multi with a behavioural shading model.
module tb_lambert_multi;
  localparam int SIZE = 16;
  localparam int FRAC = 14;
  localparam int NL   = 4;
  localparam int NM   = 4;
  localparam int ONE  = 1 << FRAC;
  localparam int AW   = $clog2(NL+1+NM);

  logic aclk = 1'b0;
  logic areset;
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [3*SIZE+9:0] cfg_wdata;

  lambert_multi_if #(.SIZE(SIZE), .NUM_MATERIALS(NM)) bus();

  lambert_multi #(
    .SIZE(SIZE), .FRAC(FRAC),
    .NUM_LIGHTS(NL), .NUM_MATERIALS(NM)
  ) dut (
    .aclk(aclk), .areset(areset), .s(bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  bit          m_en  [NL];
  int          m_int [NL];
  logic [47:0] m_dir [NL];
  int          m_amb;
  logic [23:0] m_col [NM];

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_en[l] = 0; m_int[l] = 0; m_dir[l] = '0;
    end
    m_amb = 0;
    for (int k = 0; k < NM; k++) m_col[k] = 24'hFFFFFF;
  endtask

  function automatic longint sx(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [23:0] model(logic [47:0] n, int m);
    longint acc, dot, d;
    logic [23:0] r;
    acc = m_amb;
    for (int l = 0; l < NL; l++) begin
      if (m_en[l]) begin
        dot = sx(n[15:0])  * sx(m_dir[l][15:0]) +
              sx(n[31:16]) * sx(m_dir[l][31:16]) +
              sx(n[47:32]) * sx(m_dir[l][47:32]);
        d = dot >>> FRAC;
`ifdef LAMBERT_MULTI_HALF_EN
        d = (d + ONE) >>> 1;
`endif
        if (d < 0) d = 0;
        if (d > ONE) d = ONE;
        acc = acc + (d * m_int[l]) / 256;
      end
    end
    if (acc > ONE) acc = ONE;
    for (int c = 0; c < 3; c++)
      r[8*c+:8] = 8'((acc * longint'(m_col[m][8*c+:8])) / ONE);
    return r;
  endfunction

  function automatic logic [47:0] vec(int x, int y, int z);
    return {z[15:0], y[15:0], x[15:0]};
  endfunction

  task automatic cfg(int addr, logic [3*SIZE+9:0] data);
    @(negedge aclk);
    cfg_we = 1'b1;
    cfg_addr = addr[AW-1:0];
    cfg_wdata = data;
    @(posedge aclk);
    #1 cfg_we = 1'b0;
    if (addr < NL) begin
      m_en[addr]  = data[3*SIZE+9];
      m_int[addr] = int'(data[3*SIZE+8:3*SIZE]);
      m_dir[addr] = data[3*SIZE-1:0];
    end else if (addr == NL) begin
      m_amb = int'(data[SIZE-1:0]);
    end else if (addr < NL+1+NM) begin
      m_col[addr-NL-1] = data[23:0];
    end
  endtask

  task automatic set_light(int l, bit en, int inten,
                           int x, int y, int z);
    logic [3*SIZE+9:0] w;
    w = {en, inten[8:0], z[15:0], y[15:0], x[15:0]};
    cfg(l, w);
  endtask

  task automatic drive_beat(logic [47:0] n, int m);
    @(negedge aclk);
    bus.normal_axis_tvalid = 1'b1;
    bus.normal_axis_tdata = n;
    bus.material_axis_tdata = m[1:0];
  endtask

  task automatic wait_accept(output int hs);
    int cnt = 0;
    while (bus.normal_axis_tready !== 1'b1 && cnt < 200) begin
      @(negedge aclk);
      cnt++;
    end
    if (cnt >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout tready=%b want 1",
               bus.normal_axis_tready);
    end
    @(posedge aclk);
    @(negedge aclk);
    hs = cyc;
    bus.normal_axis_tvalid = 1'b0;
  endtask

  task automatic send(logic [47:0] n, int m, output int hs);
    drive_beat(n, m);
    wait_accept(hs);
  endtask

  task automatic recv(logic [23:0] exp, string name,
                      int hs, bit chk_lat, int stall);
    int cnt = 0;
    while (bus.pixel_axis_tvalid !== 1'b1 && cnt < 200) begin
      @(negedge aclk);
      cnt++;
    end
    if (cnt >= 200) begin
      checks++; errors++;
      $display("FAIL %s valid_timeout got 0 want 1", name);
      return;
    end
    if (chk_lat) begin
      checks++;
      if (cyc - hs !== NL + 1) begin
        errors++;
        $display("FAIL %s latency got %0d edges want %0d",
                 name, cyc - hs, NL + 1);
      end
    end
    repeat (stall) @(negedge aclk);
    checks++;
    if (bus.pixel_axis_tdata !== exp) begin
      errors++;
      $display("FAIL %s pixel got %06h want %06h",
               name, bus.pixel_axis_tdata, exp);
    end
    bus.pixel_axis_tready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bus.pixel_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    checks += 3;
    if (bus.pixel_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_tvalid got %b want 0", bus.pixel_axis_tvalid);
    end
    if (bus.pixel_axis_tdata !== 24'h0) begin
      errors++;
      $display("FAIL rst_tdata got %06h want 0", bus.pixel_axis_tdata);
    end
    if (bus.normal_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_tready got %b want 0", bus.normal_axis_tready);
    end
    areset = 1'b0;
    model_reset();
    @(negedge aclk);
    @(negedge aclk);
    checks++;
    if (bus.normal_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL idle_tready got %b want 1", bus.normal_axis_tready);
    end
  endtask

  task automatic test_single();
    int hs;
    set_light(0, 1, 256, 0, 0, 16384);
    cfg(NL+1, 58'hFF8000);
    send(vec(0, 0, 16384), 0, hs);
    recv(24'hFF8000, "single", hs, 1, 0);
  endtask

  task automatic test_ambient();
    int hs;
    cfg(NL, 58'd4096);
    cfg(NL+2, 58'hFFFFFF);
    send(vec(0, 0, -16384), 1, hs);
    recv(24'h3F3F3F, "ambient", hs, 1, 0);
  endtask

  task automatic test_saturate();
    int hs;
    cfg(NL, 58'd0);
    set_light(1, 1, 256, 0, 0, 16384);
    send(vec(0, 0, 16384), 1, hs);
    recv(24'hFFFFFF, "saturate", hs, 0, 0);
    set_light(1, 0, 256, 0, 0, 16384);
    set_light(0, 1, 128, 0, 0, 16384);
    send(vec(0, 0, 16384), 1, hs);
    recv(24'h7F7F7F, "half_int", hs, 0, 0);
  endtask

  task automatic test_backpressure();
    int hs, hs2, cnt, bad;
    logic [23:0] exp_b;
    exp_b = model(vec(0, 0, 16384), 0);
    send(vec(0, 0, 16384), 1, hs);
    drive_beat(vec(0, 0, 16384), 0);
    cnt = 0;
    while (bus.pixel_axis_tvalid !== 1'b1 && cnt < 200) begin
      @(negedge aclk);
      cnt++;
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      checks += 2;
      if (bus.pixel_axis_tdata !== 24'h7F7F7F ||
          bus.pixel_axis_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold got %b/%06h want 1/7f7f7f",
                 bus.pixel_axis_tvalid, bus.pixel_axis_tdata);
      end
      if (bus.normal_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL bp_tready got %b want 0",
                 bus.normal_axis_tready);
      end
    end
    recv(24'h7F7F7F, "bp_first", hs, 0, 0);
    wait_accept(hs2);
    recv(exp_b, "bp_second", hs2, 1, 0);
    bus.pixel_axis_tready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      if (bus.pixel_axis_tvalid !== 1'b0) bad++;
    end
    bus.pixel_axis_tready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_extra got %0d valid cycles want 0", bad);
    end
  endtask

  task automatic test_throughput();
    int hs [4];
    bus.pixel_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_beat(vec(0, 0, 16384), 1);
      wait_accept(hs[k]);
    end
    repeat (10) @(negedge aclk);
    bus.pixel_axis_tready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (hs[k] - hs[k-1] !== NL + 3) begin
        errors++;
        $display("FAIL throughput got %0d want %0d",
                 hs[k] - hs[k-1], NL + 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs, bad;
    set_light(0, 1, 256, 0, 0, 16384);
    send(vec(0, 0, 16384), 0, hs);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    checks++;
    if (bus.pixel_axis_tvalid !== 1'b0 ||
        bus.normal_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_accum got %b/%b want 0/0",
               bus.pixel_axis_tvalid, bus.normal_axis_tready);
    end
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    model_reset();
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      if (bus.pixel_axis_tvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_partial got %0d valid cycles want 0", bad);
    end
    send(vec(0, 0, 16384), 0, hs);
    recv(24'h000000, "after_rst", hs, 1, 0);
    set_light(0, 1, 256, 0, 0, 16384);
    send(vec(0, 0, 16384), 0, hs);
    while (bus.pixel_axis_tvalid !== 1'b1 && cyc - hs < 50)
      @(negedge aclk);
    areset = 1'b1;
    #1;
    checks++;
    if (bus.pixel_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got %b want 0", bus.pixel_axis_tvalid);
    end
    @(negedge aclk);
    areset = 1'b0;
    model_reset();
    @(negedge aclk);
  endtask

  task automatic test_random();
    int hs, m;
    logic [47:0] n;
    for (int l = 0; l < NL; l++)
      set_light(l, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 511)),
                int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)));
    cfg(NL, 58'($urandom_range(0, 20000)));
    for (int k = 0; k < NM; k++)
      cfg(NL+1+k, 58'($urandom));
    cfg(NL+1+NM, 58'h3FF_FFFF_FFFF_FFFF);
    for (int t = 0; t < 24; t++) begin
      n = {16'($urandom), 16'($urandom), 16'($urandom)};
      m = int'($urandom_range(0, NM-1));
      send(n, m, hs);
      recv(model(n, m), "random", hs, 1,
           int'($urandom_range(0, 3)));
    end
  endtask

`ifdef LAMBERT_MULTI_HALF_EN
  task automatic test_half();
    int hs;
    for (int l = 1; l < NL; l++) set_light(l, 0, 0, 0, 0, 0);
    cfg(NL, 58'd0);
    cfg(NL+1, 58'hFFFFFF);
    set_light(0, 1, 256, 16384, 0, 0);
    send(vec(0, 0, 16384), 0, hs);
    recv(24'h7F7F7F, "half_perp", hs, 1, 0);
    send(vec(-16384, 0, 0), 0, hs);
    recv(24'h000000, "half_back", hs, 1, 0);
  endtask
`endif

  initial begin
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    bus.normal_axis_tvalid = 1'b0;
    bus.normal_axis_tdata = '0;
    bus.material_axis_tdata = '0;
    bus.pixel_axis_tready = 1'b0;
    test_reset();
    test_single();
    test_ambient();
    test_saturate();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
`ifdef LAMBERT_MULTI_HALF_EN
    test_half();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
